// File: rtl/analog_rx.sv
// -----------------------------------------------------------------------------
// analog_rx
//   Digital -> analog side of the analog macro wrapper. Accepts one spin vector
//   per valid/ready handshake, holds it stable on the macro inputs, then steps
//   through load / settle / compute phases with programmable cycle counts.
//   It finishes with a one-cycle finish pulse that analog_tx consumes.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   en_i                          block enable; low aborts to IDLE
//   rx_configure_enable_i         load settle/compute config (IDLE only)
//   settle_cycles_i               cycles between load strobe and compute start
//   cmpt_cycles_i                 cycles analog_start_o stays high (0 acts as 1)
//   spin_valid_i / spin_ready_o   spin vector handshake from digital
//   spin_i                        incoming spin vector
//   spin_o                        registered spins driven to the analog macro
//   spin_load_o                   one-cycle load strobe to the macro
//   analog_start_o                compute enable to the macro (level)
//   analog_macro_cmpt_finish_o    one-cycle finish pulse to analog_tx
//   analog_rx_idle_o              high while the FSM is in IDLE
// -----------------------------------------------------------------------------
module analog_rx #(
    parameter int unsigned NUM_SPIN          = 256,
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned DEF_SETTLE_CYCLES = 4,
    parameter int unsigned DEF_CMPT_CYCLES   = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                rx_configure_enable_i,
    input  logic [CNT_W-1:0]    settle_cycles_i,
    input  logic [CNT_W-1:0]    cmpt_cycles_i,
    input  logic                spin_valid_i,
    output logic                spin_ready_o,
    input  logic [NUM_SPIN-1:0] spin_i,
    output logic [NUM_SPIN-1:0] spin_o,
    output logic                spin_load_o,
    output logic                analog_start_o,
    output logic                analog_macro_cmpt_finish_o,
    output logic                analog_rx_idle_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    settle_q;
    logic [CNT_W-1:0]    cmpt_q;
    logic [CNT_W-1:0]    cmpt_eff;
    logic [NUM_SPIN-1:0] spin_q;
    logic                load_q, start_q, finish_q;
    logic                accept;
    logic                cfg_we;

    assign spin_ready_o     = en_i & (state_q == ST_IDLE);
    assign analog_rx_idle_o = (state_q == ST_IDLE);
    assign accept           = spin_valid_i & spin_ready_o;
    assign cfg_we           = en_i & rx_configure_enable_i & (state_q == ST_IDLE);

    // A programmed compute length of zero still runs one compute cycle.
    assign cmpt_eff = (cmpt_q == '0) ? CNT_W'(1) : cmpt_q;

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (settle_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = cmpt_eff - CNT_W'(1);
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = settle_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = cmpt_eff - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disable wins over everything: abort the transaction silently.
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State, counter and registered Moore outputs. The output flops are loaded
    // from the next state so each strobe lines up with its state cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop
            // samples the pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= (state_d == ST_LOAD);
            start_q  <= (state_d == ST_RUN);
            finish_q <= (state_d == ST_FINISH);
        end
    end

    // Config registers: writable only while idle, so they are stable for the
    // whole of any transaction. A write on the handshake edge applies to it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            settle_q <= CNT_W'(DEF_SETTLE_CYCLES);
            cmpt_q   <= CNT_W'(DEF_CMPT_CYCLES);
        end else if (cfg_we) begin
            settle_q <= settle_cycles_i;
            cmpt_q   <= cmpt_cycles_i;
        end
    end

    // Spin holding register: updated only on a handshake, never cleared by
    // abort or FINISH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this wide data register is reset because its value drives
            // the analog macro pins directly and must be defined out of reset.
            spin_q <= '0;
        end else if (accept) begin
            spin_q <= spin_i;
        end
    end

    assign spin_o                     = spin_q;
    assign spin_load_o                = load_q;
    assign analog_start_o             = start_q;
    assign analog_macro_cmpt_finish_o = finish_q;

endmodule
